tribuf_bus_arb: RTL

- Arbiter and driver sequencer for a shared tristate bus built from tribuf cells.
- Sits directly upstream of the tribuf instances: generates each cell's data input (A) and enable (E) from NUM_REQ requesters.
- Guarantees that at most one enable is active at any time.
- Inserts turnaround cycles with the bus floating (Z) between owners.

---
 rtl/tribuf_bus_arb_if.sv | 16 +
 rtl/tribuf_bus_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tribuf_bus_arb_if.sv
// Shared-tristate-bus arbiter signal bundle: requester inputs and tribuf drive outputs.
// master = requester/bench side, slave = arbiter side.
interface tribuf_bus_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] din;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ*WIDTH-1:0] drv_a;
    logic [NUM_REQ-1:0]       drv_e;
    logic                     busy;

    modport master (output req, output din, input gnt, input drv_a, input drv_e, input busy);
    modport slave  (input req, input din, output gnt, output drv_a, output drv_e, output busy);
endinterface

// File: rtl/tribuf_bus_arb.sv
// Round-robin arbiter / driver sequencer for a tribuf-built shared bus, with turnaround.
// Optional bus parking on requester 0 while idle: define TRIBUF_BUS_PARK_EN.
module tribuf_bus_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TA_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    tribuf_bus_arb_if.slave   bus
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BCNT_W = 4;
    localparam int unsigned TCNT_W = 2;
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST);
    localparam logic [TCNT_W-1:0] TA_LAST    = TCNT_W'(TA_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REQ - 1);
`ifdef TRIBUF_BUS_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_TURN = 2'd2} state_t;

    state_t                   r_state, w_state_nxt;
    logic [NUM_REQ-1:0]       r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]       r_drv_e, w_drv_e_nxt;
    logic [NUM_REQ*WIDTH-1:0] r_drv_a, w_drv_a_nxt;
    logic                     r_busy, w_busy_nxt;
    logic [IDX_W-1:0]         r_own, w_own_nxt;
    logic [IDX_W-1:0]         r_ptr, w_ptr_nxt;
    logic [BCNT_W-1:0]        r_bcnt, w_bcnt_nxt;
    logic [TCNT_W-1:0]        r_tcnt, w_tcnt_nxt;
    logic                     w_any;
    logic [IDX_W-1:0]         w_sel;
    logic [IDX_W-1:0]         w_idx;
    int                       w_pos;

    // Pick the first requester at or after the pointer; scanning far-to-near lets the nearest win.
    always_comb begin
        w_any = |bus.req;
        w_sel = r_ptr;
        w_idx = r_ptr;
        w_pos = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_pos = int'(r_ptr) + (int'(NUM_REQ) - 1 - i);
            if (w_pos >= int'(NUM_REQ)) w_pos = w_pos - int'(NUM_REQ);
            w_idx = IDX_W'(w_pos);
            if (bus.req[w_idx]) w_sel = w_idx;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_drv_e <= '0;
            r_drv_a <= '0;
            r_busy  <= 1'b0;
            r_own   <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_drv_e <= w_drv_e_nxt;
            r_drv_a <= w_drv_a_nxt;
            r_busy  <= w_busy_nxt;
            r_own   <= w_own_nxt;
            r_ptr   <= w_ptr_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Next state; a parked bus handed to another lane must float first
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    if (PARK && r_drv_e[0] && (w_sel != '0)) w_state_nxt = ST_TURN;
                    else                                     w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!bus.req[r_own] || (r_bcnt == BURST_LAST)) w_state_nxt = ST_TURN;
            end
            ST_TURN: begin
                if (r_tcnt == TA_LAST) w_state_nxt = w_any ? ST_DRIVE : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of outputs and counters, derived from the transition taken
    always_comb begin
        w_gnt_nxt   = '0;
        w_drv_e_nxt = '0;
        w_drv_a_nxt = '0;
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        w_bcnt_nxt  = r_bcnt;
        w_tcnt_nxt  = r_tcnt;
        case (w_state_nxt)
            ST_DRIVE: begin
                if (r_state == ST_DRIVE) begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end else begin
                    w_own_nxt  = w_sel;
                    w_bcnt_nxt = BCNT_W'(1);
                end
                w_gnt_nxt[w_own_nxt]   = 1'b1;
                w_drv_e_nxt[w_own_nxt] = 1'b1;
                w_drv_a_nxt[w_own_nxt*WIDTH +: WIDTH] = bus.din[w_own_nxt*WIDTH +: WIDTH];
            end
            ST_TURN: begin
                w_tcnt_nxt = (r_state == ST_TURN) ? r_tcnt + 1'b1 : '0;
                if (r_state == ST_DRIVE) w_ptr_nxt = (r_own == IDX_LAST) ? '0 : r_own + 1'b1;
            end
            default: begin
                w_drv_e_nxt[0] = PARK;
            end
        endcase
    end

    assign bus.gnt   = r_gnt;
    assign bus.drv_e = r_drv_e;
    assign bus.drv_a = r_drv_a;
    assign bus.busy  = r_busy;
endmodule
